cofre_controlador: RTL and testbench
====================================

# cofre_controlador

Sequential controller for the digital-safe datapath (comparator, two's-complement subtractor, 7-segment and LED decode). It owns the stored password, registers the user's entry, and drives both operands of the subtract/compare datapath. It reads back the 4-bit difference and runs the open/error/lockout state machine. It also overrides the RGB LEDs with the safe status.

## Interface
- `MAX_TENTATIVAS`, default 3: consecutive wrong entries before lockout (1..7).
- `ERRO_CICLOS`, default 50_000_000: cycles the error indication is held.
- `BLOQUEIO_CICLOS`, default 500_000_000: lockout duration in cycles.
- `ABERTO_CICLOS`, default 1_000_000_000: auto-relock timeout; used only with `COFRE_AUTO_FECHA_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `senha_in` in 4: password switches, level.
- `btn_confirma` in 1: confirm button, level; block edge-detects it.
- `btn_fecha` in 1: close button, level; block edge-detects it.
- `resultado` in 4: datapath difference `senha_a - senha_b`, combinational return.
- `senha_a` out 4: stored password to datapath operand a.
- `senha_b` out 4: registered entry to datapath operand b.
- `aberto` out 1: safe open.
- `bloqueado` out 1: lockout active.
- `falhas` out 3: current consecutive-failure count.
- `led_verme`, `led_verd`, `led_azu` out 1 each: status LEDs.

## Operation
- Edge detect: each button has a 1-bit previous-value register. Event = `btn & ~btn_prev`. Held buttons give one event only.
- Reset values:
  - state `CADASTRO`; `senha_a`=0, `senha_b`=0, `falhas`=0.
  - `aberto`=0, `bloqueado`=0, `led_azu`=1, `led_verme`=0, `led_verd`=0.
  - all timers 0; previous-button registers 0.
- `CADASTRO`: `led_azu`=1.
  - confirma event → `senha_a` <= `senha_in`, go to `FECHADO`.
- `FECHADO`: all LEDs 0.
  - confirma event → `senha_b` <= `senha_in`, go to `VERIFICA`.
- `VERIFICA`: one cycle only; `resultado` is sampled at the end of it.
  - `resultado`==4'h0 → `ABERTO`, `falhas` <= 0.
  - otherwise, with `falhas`+1 < `MAX_TENTATIVAS` → `ERRO`, `falhas` incremented.
  - otherwise → `BLOQUEADO`, `falhas` <= `MAX_TENTATIVAS`.
- `ABERTO`: `aberto`=1, `led_verd`=1.
  - fecha event → `FECHADO`.
  - confirma event (no fecha) → `senha_a` <= `senha_in` (password change); stay in `ABERTO`; timer restarts.
  - fecha and confirma in the same cycle: fecha wins and the password is unchanged.
- `ERRO`: `led_verme`=1.
  - timer counts to `ERRO_CICLOS`-1, then → `FECHADO`.
  - button events are ignored.
- `BLOQUEADO`: `bloqueado`=1; `led_verme` toggles every 2^24 cycles (bit 24 of the timer).
  - after `BLOQUEIO_CICLOS` cycles → `FECHADO`, `falhas` <= 0.
  - all button events are ignored.
- Timer: a single 30-bit counter, cleared on every state entry and on a password change.
- Illegal or unused state encodings go to `CADASTRO` on the next edge.

## Timing
- All outputs are registered or decoded from state only; none depend combinationally on inputs.
- Entry latency: confirma rises at edge N, giving the event in cycle N.
  - edge N+1: `senha_b` updated, state `VERIFICA`.
  - edge N+2: state is `ABERTO`, `ERRO` or `BLOQUEADO`; `aberto` or the LED output is visible after edge N+2.
- Datapath contract: `resultado` must settle within one cycle of `senha_b` changing.
- `ERRO` lasts exactly `ERRO_CICLOS` cycles. `BLOQUEADO` lasts exactly `BLOQUEIO_CICLOS` cycles.
- `reset` mid-operation, in any state, returns every output to its reset value at the next edge. The stored password is lost.

## Configuration
- `COFRE_AUTO_FECHA_EN` defined: in `ABERTO` the timer runs.
  - at `ABERTO_CICLOS`-1 the block returns to `FECHADO` with no button.
  - a password change restarts the timeout.
- Not defined: `ABERTO` is left only by a fecha event or `reset`; the timer is held at 0 in `ABERTO`.

## Test plan
- Reset, then `senha_in`=4'h9 with a confirma pulse → `senha_a`=9, state `FECHADO`, all LEDs 0.
- Enter 4'h9, datapath returns 0 → `aberto`=1 and `led_verd`=1 two cycles after the edge; `falhas`=0.
- Enter 4'h3 three times, `resultado`=6 each time:
  - first two → `led_verme`=1 for `ERRO_CICLOS` cycles, `falhas`=1 then 2.
  - third → `bloqueado`=1; confirma is ignored; after `BLOQUEIO_CICLOS` the block is in `FECHADO` with `falhas`=0.
- In `ABERTO`, fecha and confirma rise in the same cycle with `senha_in`=4'h5 → state `FECHADO`, `senha_a` still 9.
- Hold `btn_confirma` high for 100 cycles in `FECHADO` → exactly one `VERIFICA` pass.
- With `COFRE_AUTO_FECHA_EN` and `ABERTO_CICLOS`=20 (bench override) → `aberto` drops after 20 cycles. Without the macro → `aberto` stays 1 for 1000 cycles.

Source files
------------

// File: rtl/cofre_controlador.sv
// cofre_controlador: digital-safe sequencer. Holds the stored password,
// registers the user's entry, feeds both operands of the subtract/compare
// datapath and runs the open / error / lockout state machine.
// Optional feature: define COFRE_AUTO_FECHA_EN to relock automatically after
// ABERTO_CICLOS cycles in the open state.
module cofre_controlador #(
    parameter int unsigned MAX_TENTATIVAS  = 3,
    parameter int unsigned ERRO_CICLOS     = 50_000_000,
    parameter int unsigned BLOQUEIO_CICLOS = 500_000_000,
    parameter int unsigned ABERTO_CICLOS   = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] senha_in,
    input  logic       btn_confirma,
    input  logic       btn_fecha,
    input  logic [3:0] resultado,
    output logic [3:0] senha_a,
    output logic [3:0] senha_b,
    output logic       aberto,
    output logic       bloqueado,
    output logic [2:0] falhas,
    output logic       led_verme,
    output logic       led_verd,
    output logic       led_azu
);

    typedef enum logic [2:0] {
        CADASTRO  = 3'd0,
        FECHADO   = 3'd1,
        VERIFICA  = 3'd2,
        ABERTO    = 3'd3,
        ERRO      = 3'd4,
        BLOQUEADO = 3'd5
    } estado_t;

`ifdef COFRE_AUTO_FECHA_EN
    localparam bit AUTO_FECHA = 1'b1;
`else
    localparam bit AUTO_FECHA = 1'b0;
`endif

    // Last timer value of each timed state (timer starts at 0 on entry).
    localparam logic [29:0] ERRO_FIM   = 30'(ERRO_CICLOS - 1);
    localparam logic [29:0] BLOQ_FIM   = 30'(BLOQUEIO_CICLOS - 1);
    localparam logic [29:0] ABERTO_FIM = 30'(ABERTO_CICLOS - 1);
    localparam logic [2:0]  MAX_F      = 3'(MAX_TENTATIVAS);

    estado_t     state_q, state_d;
    logic [3:0]  senha_a_q, senha_a_d;
    logic [3:0]  senha_b_q, senha_b_d;
    logic [2:0]  falhas_q, falhas_d;
    logic [29:0] timer_q, timer_d;
    logic        confirma_prev_q;
    logic        fecha_prev_q;
    logic        ev_confirma;
    logic        ev_fecha;

    assign ev_confirma = btn_confirma & ~confirma_prev_q;
    assign ev_fecha    = btn_fecha & ~fecha_prev_q;

    // State, datapath operands, failure count, timer and button history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= CADASTRO;
            senha_a_q       <= 4'h0;
            senha_b_q       <= 4'h0;
            falhas_q        <= 3'd0;
            timer_q         <= 30'd0;
            confirma_prev_q <= 1'b0;
            fecha_prev_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            senha_a_q       <= senha_a_d;
            senha_b_q       <= senha_b_d;
            falhas_q        <= falhas_d;
            timer_q         <= timer_d;
            confirma_prev_q <= btn_confirma;
            fecha_prev_q    <= btn_fecha;
        end
    end

    // Next-state logic; the timer only advances in timed states.
    always_comb begin
        state_d   = state_q;
        senha_a_d = senha_a_q;
        senha_b_d = senha_b_q;
        falhas_d  = falhas_q;
        timer_d   = timer_q + 30'd1;
        case (state_q)
            CADASTRO: begin
                timer_d = 30'd0;
                if (ev_confirma) begin
                    senha_a_d = senha_in;
                    state_d   = FECHADO;
                end
            end
            FECHADO: begin
                timer_d = 30'd0;
                if (ev_confirma) begin
                    senha_b_d = senha_in;
                    state_d   = VERIFICA;
                end
            end
            VERIFICA: begin
                timer_d = 30'd0;
                if (resultado == 4'h0) begin
                    state_d  = ABERTO;
                    falhas_d = 3'd0;
                end else if (({1'b0, falhas_q} + 4'd1) < {1'b0, MAX_F}) begin
                    state_d  = ERRO;
                    falhas_d = falhas_q + 3'd1;
                end else begin
                    state_d  = BLOQUEADO;
                    falhas_d = MAX_F;
                end
            end
            ABERTO: begin
                if (!AUTO_FECHA) begin
                    timer_d = 30'd0;
                end
                // Close has priority over a simultaneous password change.
                if (ev_fecha) begin
                    state_d = FECHADO;
                    timer_d = 30'd0;
                end else if (ev_confirma) begin
                    senha_a_d = senha_in;
                    timer_d   = 30'd0;
                end else if (AUTO_FECHA && timer_q == ABERTO_FIM) begin
                    state_d = FECHADO;
                    timer_d = 30'd0;
                end
            end
            ERRO: begin
                if (timer_q == ERRO_FIM) begin
                    state_d = FECHADO;
                    timer_d = 30'd0;
                end
            end
            BLOQUEADO: begin
                if (timer_q == BLOQ_FIM) begin
                    state_d  = FECHADO;
                    falhas_d = 3'd0;
                    timer_d  = 30'd0;
                end
            end
            default: begin
                state_d = CADASTRO;
                timer_d = 30'd0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    assign senha_a   = senha_a_q;
    assign senha_b   = senha_b_q;
    assign falhas    = falhas_q;
    assign aberto    = (state_q == ABERTO);
    assign bloqueado = (state_q == BLOQUEADO);
    assign led_azu   = (state_q == CADASTRO);
    assign led_verd  = (state_q == ABERTO);
    assign led_verme = (state_q == ERRO) | ((state_q == BLOQUEADO) & timer_q[24]);

endmodule

// File: tb/tb_cofre_controlador.sv
// Bench for cofre_controlador: a mode/remaining-cycles model of the safe is
// compared with the DUT every cycle, plus literal checks at key points.
module tb_cofre_controlador;

    localparam int MAX_T = 3;
    localparam int ERR_C = 10;
    localparam int BLQ_C = 40;
    localparam int ABT_C = 20;
`ifdef COFRE_AUTO_FECHA_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] senha_in = 4'h0;
    logic       btn_confirma = 1'b0;
    logic       btn_fecha = 1'b0;
    logic [3:0] resultado;
    logic [3:0] senha_a, senha_b;
    logic       aberto, bloqueado;
    logic [2:0] falhas;
    logic       led_verme, led_verd, led_azu;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: modes named after the safe's behaviour.
    localparam int M_CAD = 0, M_FECH = 1, M_VER = 2, M_AB = 3, M_ERR = 4, M_BLQ = 5;
    int m_mode = M_CAD;
    int m_sa = 0, m_sb = 0, m_fal = 0, m_rem = 0;
    bit m_pc = 1'b0, m_pf = 1'b0;

    always #5 clk = ~clk;

    // Datapath stand-in: difference of the two operands.
    assign resultado = senha_a - senha_b;

    cofre_controlador #(
        .MAX_TENTATIVAS (MAX_T),
        .ERRO_CICLOS    (ERR_C),
        .BLOQUEIO_CICLOS(BLQ_C),
        .ABERTO_CICLOS  (ABT_C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .senha_in    (senha_in),
        .btn_confirma(btn_confirma),
        .btn_fecha   (btn_fecha),
        .resultado   (resultado),
        .senha_a     (senha_a),
        .senha_b     (senha_b),
        .aberto      (aberto),
        .bloqueado   (bloqueado),
        .falhas      (falhas),
        .led_verme   (led_verme),
        .led_verd    (led_verd),
        .led_azu     (led_azu)
    );

    // Reference model: advance one cycle on each rising edge.
    always @(posedge clk) begin
        bit ec, ef;
        int d;
        ec = btn_confirma && !m_pc;
        ef = btn_fecha && !m_pf;
        if (reset) begin
            m_mode = M_CAD; m_sa = 0; m_sb = 0; m_fal = 0; m_rem = 0;
            m_pc = 1'b0; m_pf = 1'b0;
        end else begin
            m_pc = btn_confirma;
            m_pf = btn_fecha;
            case (m_mode)
                M_CAD: if (ec) begin m_sa = senha_in; m_mode = M_FECH; end
                M_FECH: if (ec) begin m_sb = senha_in; m_mode = M_VER; end
                M_VER: begin
                    d = (m_sa - m_sb) & 15;
                    if (d == 0) begin
                        m_mode = M_AB; m_fal = 0; m_rem = ABT_C;
                    end else if (m_fal + 1 < MAX_T) begin
                        m_mode = M_ERR; m_fal = m_fal + 1; m_rem = ERR_C;
                    end else begin
                        m_mode = M_BLQ; m_fal = MAX_T; m_rem = BLQ_C;
                    end
                end
                M_AB: begin
                    if (ef) m_mode = M_FECH;
                    else if (ec) begin m_sa = senha_in; m_rem = ABT_C; end
                    else if (AUTO) begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_mode = M_FECH;
                    end
                end
                M_ERR: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_FECH;
                end
                M_BLQ: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_mode = M_FECH; m_fal = 0; end
                end
                default: m_mode = M_CAD;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [14:0] got, exp;
        bit ev;
        if (chk_en) begin
            ev = (m_mode == M_ERR) ||
                 (m_mode == M_BLQ && (((BLQ_C - m_rem) >> 24) & 1) == 1);
            exp = {4'(m_sa), 4'(m_sb), m_mode == M_AB, m_mode == M_BLQ, 3'(m_fal),
                   ev, m_mode == M_AB, m_mode == M_CAD};
            got = {senha_a, senha_b, aberto, bloqueado, falhas, led_verme, led_verd, led_azu};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got=%h required=%h (mode %0d)", $time, got, exp, m_mode);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic press(input logic c, input logic f);
        @(negedge clk);
        btn_confirma = c;
        btn_fecha = f;
        @(negedge clk);
        btn_confirma = 1'b0;
        btn_fecha = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        wait_cyc(3);
        check("reset_senha_a", senha_a, 0);
        check("reset_led_azu", led_azu, 1);
        reset = 1'b0;

        // Register password 9.
        senha_in = 4'h9;
        press(1'b1, 1'b0);
        check("cadastro_senha_a", senha_a, 9);
        check("fechado_leds", {led_verme, led_verd, led_azu}, 0);

        // Correct entry opens two edges after the event.
        press(1'b1, 1'b0);
        @(negedge clk);
        check("abre_aberto", aberto, 1);
        check("abre_led_verd", led_verd, 1);
        check("abre_falhas", falhas, 0);

        // Simultaneous close and confirm: close wins, password unchanged.
        senha_in = 4'h5;
        press(1'b1, 1'b1);
        check("fecha_vence_aberto", aberto, 0);
        check("fecha_vence_senha_a", senha_a, 9);

        // Two wrong entries then lockout.
        senha_in = 4'h3;
        for (int k = 1; k <= 2; k++) begin
            press(1'b1, 1'b0);
            @(negedge clk);
            check("erro_led_verme", led_verme, 1);
            check("erro_falhas", falhas, k);
            wait_cyc(ERR_C + 2);
        end
        press(1'b1, 1'b0);
        @(negedge clk);
        check("bloq_bloqueado", bloqueado, 1);
        check("bloq_falhas", falhas, MAX_T);
        press(1'b1, 1'b0);
        check("bloq_ignora_confirma", bloqueado, 1);
        wait_cyc(BLQ_C + 2);
        check("bloq_fim_bloqueado", bloqueado, 0);
        check("bloq_fim_falhas", falhas, 0);

        // Held confirm gives a single verification.
        @(negedge clk);
        btn_confirma = 1'b1;
        wait_cyc(100);
        btn_confirma = 1'b0;
        check("segurado_falhas", falhas, 1);

        // Open again, change password, then watch the open period.
        senha_in = 4'h9;
        press(1'b1, 1'b0);
        @(negedge clk);
        check("reabre_aberto", aberto, 1);
        check("reabre_falhas", falhas, 0);
        senha_in = 4'h7;
        press(1'b1, 1'b0);
        check("troca_senha_a", senha_a, 7);
        wait_cyc(1000);
        check("aberto_apos_1000", aberto, AUTO ? 0 : 1);

        // Reset mid-operation.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_meio_senha_a", senha_a, 0);
        check("reset_meio_led_azu", led_azu, 1);
        check("reset_meio_aberto", aberto, 0);
        reset = 1'b0;
        wait_cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
